// File: rtl/tlc5920_matrix.sv
// Row-multiplexed LED matrix controller for a TLC5920-style serial driver.
// Optional PWM brightness control is compiled in with TLC_BRIGHTNESS_EN.
module tlc5920_matrix #(
  parameter int g_divider  = 9,
  parameter int g_rows     = 4,
  parameter int g_columns  = 16,
  parameter int g_states   = 2,
  parameter int g_rowTicks = 256,
  localparam int ROW_BITS  = g_states * g_columns,
  localparam int CSEL_W    = (g_rows > 1) ? $clog2(g_rows) : 1
) (
  input  logic                         Clk_ik,
  input  logic                         Rst_ir,
  input  logic [g_rows*ROW_BITS-1:0]   ledData_ib,
  input  logic                         update_i,
  input  logic [7:0]                   brightness_ib8,
  output logic                         sclk_o,
  output logic                         data_o,
  output logic                         latch_o,
  output logic                         blank_o,
  output logic [CSEL_W-1:0]            csel_ob,
  output logic                         frameDone_o
);

  localparam int FRAME_BITS  = g_rows * ROW_BITS;
  localparam int SHIFT_TICKS = 2 * ROW_BITS;
  localparam int MAX_TICKS   = (SHIFT_TICKS > g_rowTicks) ? SHIFT_TICKS : g_rowTicks;
  localparam int PH_W        = $clog2(MAX_TICKS);
  localparam int DIV_W       = (g_divider > 0) ? $clog2(g_divider + 1) : 1;

  typedef enum logic [1:0] {BLANK, SHIFT, LATCH, DISPLAY} state_t;

  state_t                state, state_next;
  logic [DIV_W-1:0]      div_cnt;
  logic                  tick;
  logic [PH_W-1:0]       phase_cnt, phase_next;
  logic [CSEL_W-1:0]     row, row_next;
  logic                  row_last;
  logic                  load_row, shift_en, enter_display, row_wrap;
  logic                  frame_done;
  logic [ROW_BITS-1:0]   shift_reg;
  logic [FRAME_BITS-1:0] shadow_buf, active_buf;
  logic                  pending;
  logic                  display_blank;

  assign tick     = (div_cnt == DIV_W'(g_divider));
  assign row_last = (row == CSEL_W'(g_rows - 1));

  always_ff @(posedge Clk_ik or posedge Rst_ir) begin
    if (Rst_ir)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge Clk_ik or posedge Rst_ir) begin
    if (Rst_ir) begin
      state      <= BLANK;
      phase_cnt  <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      phase_cnt  <= phase_next;
      row        <= row_next;
      frame_done <= row_wrap;
    end
  end

  // The row slice is loaded when leaving BLANK so that a frame transfer made
  // on the wrap edge is already visible to row 0.
  always_comb begin
    state_next    = state;
    phase_next    = phase_cnt;
    row_next      = row;
    load_row      = 1'b0;
    shift_en      = 1'b0;
    enter_display = 1'b0;
    row_wrap      = 1'b0;
    if (tick) begin
      case (state)
        BLANK: begin
          state_next = SHIFT;
          phase_next = '0;
          load_row   = 1'b1;
        end
        SHIFT: begin
          shift_en = phase_cnt[0];
          if (phase_cnt == PH_W'(SHIFT_TICKS - 1)) begin
            state_next = LATCH;
            phase_next = '0;
          end else begin
            phase_next = phase_cnt + 1'b1;
          end
        end
        LATCH: begin
          state_next    = DISPLAY;
          phase_next    = '0;
          enter_display = 1'b1;
        end
        DISPLAY: begin
          if (phase_cnt == PH_W'(g_rowTicks - 1)) begin
            state_next = BLANK;
            phase_next = '0;
            row_wrap   = row_last;
            row_next   = row_last ? '0 : row + 1'b1;
          end else begin
            phase_next = phase_cnt + 1'b1;
          end
        end
        default: state_next = BLANK;
      endcase
    end
  end

  always_comb begin
    sclk_o      = (state == SHIFT) & phase_cnt[0];
    data_o      = (state == SHIFT) & shift_reg[ROW_BITS-1];
    latch_o     = (state == LATCH);
    blank_o     = (state != DISPLAY) | display_blank;
    csel_ob     = row;
    frameDone_o = frame_done;
  end

  // A new bit is exposed as sclk falls, after the high half-period of the previous one.
  always_ff @(posedge Clk_ik or posedge Rst_ir) begin
    if (Rst_ir)
      shift_reg <= '0;
    else if (load_row)
      shift_reg <= active_buf[int'(row)*ROW_BITS +: ROW_BITS];
    else if (shift_en)
      shift_reg <= shift_reg << 1;
  end

  // Non-blocking reads make a coincident strobe land after the transfer.
  always_ff @(posedge Clk_ik or posedge Rst_ir) begin
    if (Rst_ir) begin
      shadow_buf <= '0;
      active_buf <= '0;
      pending    <= 1'b0;
    end else begin
      if (update_i)
        shadow_buf <= ledData_ib;
      if (row_wrap && pending)
        active_buf <= shadow_buf;
      if (update_i)
        pending <= 1'b1;
      else if (row_wrap)
        pending <= 1'b0;
    end
  end

`ifdef TLC_BRIGHTNESS_EN
  logic [7:0] pwm_cnt;
  logic [7:0] bright_q;

  always_ff @(posedge Clk_ik or posedge Rst_ir) begin
    if (Rst_ir) begin
      pwm_cnt  <= '0;
      bright_q <= '0;
    end else if (enter_display) begin
      pwm_cnt  <= '0;
      bright_q <= brightness_ib8;
    end else if (tick && state == DISPLAY) begin
      pwm_cnt  <= pwm_cnt + 1'b1;
    end
  end

  assign display_blank = (pwm_cnt >= bright_q);
`else
  logic unused_brightness;
  assign unused_brightness = ^{brightness_ib8, enter_display};
  assign display_blank     = 1'b0;
`endif

endmodule
